// File: rtl/regfile_write_arbiter_if.sv
// Bundle of the write-back sources, scoreboard query and register-file write
// port seen by regfile_write_arbiter. The master side drives results and
// queries; the slave side is the arbiter itself.
interface regfile_write_arbiter_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int FIFO_DEPTH = 4
);
    localparam int CNT_WIDTH = $clog2(FIFO_DEPTH) + 1;

    logic                  AluWriteValid;
    logic [ADDR_WIDTH-1:0] AluWriteRegister;
    logic [DATA_WIDTH-1:0] AluWriteData;
    logic                  MdWriteValid;
    logic                  MdWriteReady;
    logic [ADDR_WIDTH-1:0] MdWriteRegister;
    logic [DATA_WIDTH-1:0] MdWriteData;
    logic                  IssueValid;
    logic [ADDR_WIDTH-1:0] IssueRegister;
    logic [ADDR_WIDTH-1:0] ReadRegister1;
    logic [ADDR_WIDTH-1:0] ReadRegister2;
    logic                  Busy1;
    logic                  Busy2;
    logic [ADDR_WIDTH-1:0] WriteRegister;
    logic [DATA_WIDTH-1:0] WriteData;
    logic                  WriteEnable;
    logic [CNT_WIDTH-1:0]  FifoCount;

    modport master (
        output AluWriteValid, AluWriteRegister, AluWriteData,
        output MdWriteValid, MdWriteRegister, MdWriteData,
        output IssueValid, IssueRegister, ReadRegister1, ReadRegister2,
        input  MdWriteReady, Busy1, Busy2,
        input  WriteRegister, WriteData, WriteEnable, FifoCount
    );

    modport slave (
        input  AluWriteValid, AluWriteRegister, AluWriteData,
        input  MdWriteValid, MdWriteRegister, MdWriteData,
        input  IssueValid, IssueRegister, ReadRegister1, ReadRegister2,
        output MdWriteReady, Busy1, Busy2,
        output WriteRegister, WriteData, WriteEnable, FifoCount
    );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Write-side front end of the MIPS register file. ALU/load results always win
// the single write port; mult/div results wait in a small circular buffer and
// drain whenever the ALU path is idle. A pending-bit scoreboard lets the
// hazard unit stall readers of registers still awaiting a mult/div result.
module regfile_write_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    regfile_write_arbiter_if.slave bus
);
    localparam int PTR_WIDTH = $clog2(FIFO_DEPTH);
    localparam int CNT_WIDTH = PTR_WIDTH + 1;
    localparam int NUM_REGS  = 1 << ADDR_WIDTH;
    localparam int ENT_WIDTH = ADDR_WIDTH + DATA_WIDTH;

    localparam logic [PTR_WIDTH-1:0]  PTR_ONE   = PTR_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0]  CNT_ONE   = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0]  CNT_ZERO  = CNT_WIDTH'(0);
    localparam logic [CNT_WIDTH-1:0]  CNT_DEPTH = CNT_WIDTH'(FIFO_DEPTH);
    localparam logic [ADDR_WIDTH-1:0] REG_ZERO  = ADDR_WIDTH'(0);

    // Buffer storage: each entry is {destination, data}
    logic [ENT_WIDTH-1:0]  mem_q [FIFO_DEPTH];
    logic [PTR_WIDTH-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_WIDTH-1:0]  wr_ptr_q, wr_ptr_d;
    logic [CNT_WIDTH-1:0]  count_q, count_d;

    // Output write slot and its source flag
    logic                  we_q, we_d;
    logic                  from_md_q, from_md_d;
    logic [ADDR_WIDTH-1:0] wreg_q, wreg_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;

    logic [NUM_REGS-1:0]   pending_q, pending_d;

    logic                  ready_s;
    logic                  alu_take_s;
    logic                  push_s;
    logic                  pop_s;
    logic [ENT_WIDTH-1:0]  head_s;

    // Handshake and arbitration decisions; a write to r0 never counts as real
    always_comb begin
        ready_s    = (count_q < CNT_DEPTH);
        alu_take_s = bus.AluWriteValid && (bus.AluWriteRegister != REG_ZERO);
        push_s     = bus.MdWriteValid && ready_s && (bus.MdWriteRegister != REG_ZERO);
        pop_s      = !alu_take_s && (count_q != CNT_ZERO);
        head_s     = mem_q[rd_ptr_q];
    end

    // Next-state for the write slot, buffer pointers/count and scoreboard
    always_comb begin
        we_d      = 1'b0;
        from_md_d = 1'b0;
        wreg_d    = wreg_q;
        wdata_d   = wdata_q;
        rd_ptr_d  = rd_ptr_q;
        wr_ptr_d  = wr_ptr_q;
        count_d   = count_q;
        pending_d = pending_q;

        if (alu_take_s) begin
            we_d    = 1'b1;
            wreg_d  = bus.AluWriteRegister;
            wdata_d = bus.AluWriteData;
        end else if (pop_s) begin
            we_d      = 1'b1;
            from_md_d = 1'b1;
            wreg_d    = head_s[ENT_WIDTH-1:DATA_WIDTH];
            wdata_d   = head_s[DATA_WIDTH-1:0];
            rd_ptr_d  = rd_ptr_q + PTR_ONE;
        end else begin
            we_d = 1'b0;
        end

        if (push_s) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase

        // Clear first so that a same-edge issue to the same register wins
        if (we_q && from_md_q) begin
            pending_d[wreg_q] = 1'b0;
        end else begin
            pending_d = pending_d;
        end
        if (bus.IssueValid && (bus.IssueRegister != REG_ZERO)) begin
            pending_d[bus.IssueRegister] = 1'b1;
        end else begin
            pending_d = pending_d;
        end
    end

    // State registers; reset discards buffered results and pending bits
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= {ENT_WIDTH{1'b0}};
            end
            rd_ptr_q  <= {PTR_WIDTH{1'b0}};
            wr_ptr_q  <= {PTR_WIDTH{1'b0}};
            count_q   <= CNT_ZERO;
            we_q      <= 1'b0;
            from_md_q <= 1'b0;
            wreg_q    <= REG_ZERO;
            wdata_q   <= {DATA_WIDTH{1'b0}};
            pending_q <= {NUM_REGS{1'b0}};
        end else begin
            if (push_s) begin
                mem_q[wr_ptr_q] <= {bus.MdWriteRegister, bus.MdWriteData};
            end
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            count_q   <= count_d;
            we_q      <= we_d;
            from_md_q <= from_md_d;
            wreg_q    <= wreg_d;
            wdata_q   <= wdata_d;
            pending_q <= pending_d;
        end
    end

    // Outputs: Ready from the registered count only, gated by reset
    always_comb begin
        bus.MdWriteReady  = rst_n & ready_s;
        bus.Busy1         = pending_q[bus.ReadRegister1] && (bus.ReadRegister1 != REG_ZERO);
        bus.Busy2         = pending_q[bus.ReadRegister2] && (bus.ReadRegister2 != REG_ZERO);
        bus.WriteEnable   = we_q;
        bus.WriteRegister = wreg_q;
        bus.WriteData     = wdata_q;
        bus.FifoCount     = count_q;
    end
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter: one task per scenario, each with
// hand-computed expectations, sampled 1 time unit after the rising edge.
module tb_regfile_write_arbiter;
    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    regfile_write_arbiter_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .FIFO_DEPTH(4)) bus ();

    regfile_write_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .FIFO_DEPTH(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.AluWriteValid    = 1'b0;
        bus.AluWriteRegister = 5'd0;
        bus.AluWriteData     = 32'd0;
        bus.MdWriteValid     = 1'b0;
        bus.MdWriteRegister  = 5'd0;
        bus.MdWriteData      = 32'd0;
        bus.IssueValid       = 1'b0;
        bus.IssueRegister    = 5'd0;
    endtask

    task automatic test_reset();
        idle_inputs();
        bus.ReadRegister1 = 5'd9;
        bus.ReadRegister2 = 5'd0;
        rst_n = 1'b0;
        #12;
        total++; if (bus.WriteEnable !== 1'b0) begin bad++; $display("FAIL reset_we got=%b want=0", bus.WriteEnable); end
        total++; if (bus.WriteRegister !== 5'd0) begin bad++; $display("FAIL reset_wreg got=%0d want=0", bus.WriteRegister); end
        total++; if (bus.WriteData !== 32'd0) begin bad++; $display("FAIL reset_wdata got=%h want=0", bus.WriteData); end
        total++; if (bus.FifoCount !== 3'd0) begin bad++; $display("FAIL reset_count got=%0d want=0", bus.FifoCount); end
        total++; if (bus.MdWriteReady !== 1'b0) begin bad++; $display("FAIL reset_ready got=%b want=0", bus.MdWriteReady); end
        total++; if (bus.Busy1 !== 1'b0 || bus.Busy2 !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b%b want=00", bus.Busy1, bus.Busy2); end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        total++; if (bus.MdWriteReady !== 1'b1) begin bad++; $display("FAIL release_ready got=%b want=1", bus.MdWriteReady); end
        tick();
    endtask

    task automatic test_alu_write();
        bus.AluWriteValid    = 1'b1;
        bus.AluWriteRegister = 5'd5;
        bus.AluWriteData     = 32'h0000_1234;
        tick();
        idle_inputs();
        total++; if (bus.WriteEnable !== 1'b1) begin bad++; $display("FAIL alu_we got=%b want=1", bus.WriteEnable); end
        total++; if (bus.WriteRegister !== 5'd5) begin bad++; $display("FAIL alu_wreg got=%0d want=5", bus.WriteRegister); end
        total++; if (bus.WriteData !== 32'h0000_1234) begin bad++; $display("FAIL alu_wdata got=%h want=00001234", bus.WriteData); end
        tick();
        total++; if (bus.WriteEnable !== 1'b0) begin bad++; $display("FAIL alu_we_drop got=%b want=0", bus.WriteEnable); end
        total++; if (bus.WriteRegister !== 5'd5) begin bad++; $display("FAIL alu_wreg_hold got=%0d want=5", bus.WriteRegister); end
    endtask

    task automatic test_md_scoreboard();
        bus.ReadRegister1 = 5'd9;
        bus.ReadRegister2 = 5'd0;
        bus.IssueValid    = 1'b1;
        bus.IssueRegister = 5'd9;
        tick();
        idle_inputs();
        total++; if (bus.Busy1 !== 1'b1) begin bad++; $display("FAIL issue_busy1 got=%b want=1", bus.Busy1); end
        total++; if (bus.Busy2 !== 1'b0) begin bad++; $display("FAIL issue_busy2_r0 got=%b want=0", bus.Busy2); end
        bus.MdWriteValid    = 1'b1;
        bus.MdWriteRegister = 5'd9;
        bus.MdWriteData     = 32'hDEAD_BEEF;
        tick();
        idle_inputs();
        total++; if (bus.FifoCount !== 3'd1) begin bad++; $display("FAIL md_push_count got=%0d want=1", bus.FifoCount); end
        total++; if (bus.WriteEnable !== 1'b0) begin bad++; $display("FAIL md_push_we got=%b want=0", bus.WriteEnable); end
        tick();
        total++; if (bus.WriteEnable !== 1'b1 || bus.WriteRegister !== 5'd9 || bus.WriteData !== 32'hDEAD_BEEF) begin
            bad++; $display("FAIL md_pop_slot got=%b/%0d/%h want=1/9/deadbeef", bus.WriteEnable, bus.WriteRegister, bus.WriteData); end
        total++; if (bus.Busy1 !== 1'b1) begin bad++; $display("FAIL md_pop_busy_still got=%b want=1", bus.Busy1); end
        total++; if (bus.FifoCount !== 3'd0) begin bad++; $display("FAIL md_pop_count got=%0d want=0", bus.FifoCount); end
        tick();
        total++; if (bus.Busy1 !== 1'b0) begin bad++; $display("FAIL md_clear_busy got=%b want=0", bus.Busy1); end
        total++; if (bus.WriteEnable !== 1'b0) begin bad++; $display("FAIL md_after_we got=%b want=0", bus.WriteEnable); end
    endtask

    task automatic test_starvation();
        for (int i = 1; i <= 4; i++) begin
            bus.AluWriteValid    = 1'b1;
            bus.AluWriteRegister = 5'd20;
            bus.AluWriteData     = 32'h0000_00A0 + 32'(i);
            bus.MdWriteValid     = 1'b1;
            bus.MdWriteRegister  = 5'(i);
            bus.MdWriteData      = 32'h0000_0100 + 32'(i);
            tick();
            total++; if (bus.WriteEnable !== 1'b1 || bus.WriteRegister !== 5'd20 || bus.WriteData !== (32'h0000_00A0 + 32'(i))) begin
                bad++; $display("FAIL starve_alu_slot i=%0d got=%b/%0d/%h", i, bus.WriteEnable, bus.WriteRegister, bus.WriteData); end
        end
        idle_inputs();
        total++; if (bus.FifoCount !== 3'd4) begin bad++; $display("FAIL starve_count got=%0d want=4", bus.FifoCount); end
        total++; if (bus.MdWriteReady !== 1'b0) begin bad++; $display("FAIL starve_full_ready got=%b want=0", bus.MdWriteReady); end
        for (int i = 1; i <= 4; i++) begin
            tick();
            total++; if (bus.WriteEnable !== 1'b1 || bus.WriteRegister !== 5'(i) || bus.WriteData !== (32'h0000_0100 + 32'(i))) begin
                bad++; $display("FAIL drain_slot i=%0d got=%b/%0d/%h", i, bus.WriteEnable, bus.WriteRegister, bus.WriteData); end
            total++; if (bus.FifoCount !== 3'(4 - i)) begin bad++; $display("FAIL drain_count i=%0d got=%0d want=%0d", i, bus.FifoCount, 4 - i); end
            total++; if (bus.MdWriteReady !== 1'b1) begin bad++; $display("FAIL drain_ready i=%0d got=%b want=1", i, bus.MdWriteReady); end
        end
        tick();
        total++; if (bus.WriteEnable !== 1'b0) begin bad++; $display("FAIL drain_done_we got=%b want=0", bus.WriteEnable); end
    endtask

    task automatic test_reg0();
        bus.MdWriteValid    = 1'b1;
        bus.MdWriteRegister = 5'd11;
        bus.MdWriteData     = 32'h0000_AAAA;
        bus.AluWriteValid   = 1'b1;
        bus.AluWriteRegister = 5'd22;
        bus.AluWriteData    = 32'h0000_0022;
        tick();
        idle_inputs();
        total++; if (bus.FifoCount !== 3'd1) begin bad++; $display("FAIL r0_setup_count got=%0d want=1", bus.FifoCount); end
        bus.AluWriteValid    = 1'b1;
        bus.AluWriteRegister = 5'd0;
        bus.AluWriteData     = 32'h0000_5555;
        tick();
        idle_inputs();
        total++; if (bus.WriteEnable !== 1'b1 || bus.WriteRegister !== 5'd11 || bus.WriteData !== 32'h0000_AAAA) begin
            bad++; $display("FAIL alu_r0_drains got=%b/%0d/%h want=1/11/0000aaaa", bus.WriteEnable, bus.WriteRegister, bus.WriteData); end
        total++; if (bus.FifoCount !== 3'd0) begin bad++; $display("FAIL alu_r0_count got=%0d want=0", bus.FifoCount); end
        bus.MdWriteValid    = 1'b1;
        bus.MdWriteRegister = 5'd0;
        bus.MdWriteData     = 32'h0000_0BAD;
        #1;
        total++; if (bus.MdWriteReady !== 1'b1) begin bad++; $display("FAIL md_r0_ready got=%b want=1", bus.MdWriteReady); end
        tick();
        idle_inputs();
        total++; if (bus.FifoCount !== 3'd0) begin bad++; $display("FAIL md_r0_count got=%0d want=0", bus.FifoCount); end
        tick();
        total++; if (bus.WriteEnable !== 1'b0) begin bad++; $display("FAIL md_r0_no_write got=%b want=0", bus.WriteEnable); end
    endtask

    task automatic test_set_wins();
        bus.ReadRegister1 = 5'd7;
        bus.IssueValid    = 1'b1;
        bus.IssueRegister = 5'd7;
        tick();
        idle_inputs();
        bus.MdWriteValid    = 1'b1;
        bus.MdWriteRegister = 5'd7;
        bus.MdWriteData     = 32'h0000_0077;
        tick();
        idle_inputs();
        tick();
        total++; if (bus.WriteEnable !== 1'b1 || bus.WriteRegister !== 5'd7) begin
            bad++; $display("FAIL setwin_pop got=%b/%0d want=1/7", bus.WriteEnable, bus.WriteRegister); end
        bus.IssueValid    = 1'b1;
        bus.IssueRegister = 5'd7;
        tick();
        idle_inputs();
        total++; if (bus.Busy1 !== 1'b1) begin bad++; $display("FAIL setwin_busy got=%b want=1", bus.Busy1); end
        tick();
        total++; if (bus.Busy1 !== 1'b1) begin bad++; $display("FAIL setwin_busy_hold got=%b want=1", bus.Busy1); end
    endtask

    task automatic test_async_reset();
        bus.ReadRegister1 = 5'd12;
        for (int i = 0; i < 3; i++) begin
            bus.AluWriteValid    = 1'b1;
            bus.AluWriteRegister = 5'd21;
            bus.AluWriteData     = 32'h0000_0021;
            bus.MdWriteValid     = 1'b1;
            bus.MdWriteRegister  = 5'(13 + i);
            bus.MdWriteData      = 32'(i);
            bus.IssueValid       = (i == 0);
            bus.IssueRegister    = 5'd12;
            tick();
        end
        bus.MdWriteValid = 1'b0;
        bus.IssueValid   = 1'b0;
        total++; if (bus.FifoCount !== 3'd3 || bus.WriteEnable !== 1'b1 || bus.Busy1 !== 1'b1) begin
            bad++; $display("FAIL arst_setup got=%0d/%b/%b want=3/1/1", bus.FifoCount, bus.WriteEnable, bus.Busy1); end
        #1;
        rst_n = 1'b0;
        #1;
        total++; if (bus.WriteEnable !== 1'b0) begin bad++; $display("FAIL arst_we got=%b want=0", bus.WriteEnable); end
        total++; if (bus.FifoCount !== 3'd0) begin bad++; $display("FAIL arst_count got=%0d want=0", bus.FifoCount); end
        total++; if (bus.Busy1 !== 1'b0) begin bad++; $display("FAIL arst_busy got=%b want=0", bus.Busy1); end
        total++; if (bus.MdWriteReady !== 1'b0) begin bad++; $display("FAIL arst_ready got=%b want=0", bus.MdWriteReady); end
        idle_inputs();
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        total++; if (bus.WriteEnable !== 1'b0 || bus.FifoCount !== 3'd0) begin
            bad++; $display("FAIL arst_after got=%b/%0d want=0/0", bus.WriteEnable, bus.FifoCount); end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        bus.ReadRegister1 = 5'd0;
        bus.ReadRegister2 = 5'd0;
        idle_inputs();
        test_reset();
        test_alu_write();
        test_md_scoreboard();
        test_starvation();
        test_reg0();
        test_set_wins();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
